tl_a_repeater: RTL and testbench
================================

Name: tl_a_repeater

Overview:
- Single-entry TileLink A-channel repeater that captures a request beat and replays it on `deq` while `repeat` is held.
- Typical use: a fragmenter breaks one wide request into several narrow beats; this block holds the original beat so the fragmenter can re-issue it.
- Sits directly upstream of the repeater protocol checker, which flags a `deq` beat whose mask is not all-ones.
- When `repeat` is low, the block is a zero-latency pass-through.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; mask width is DATA_W/8 (4 at default).
- SOURCE_W, 4, source ID width.
- SIZE_W, 3, size field width.
- CNT_W, 8, width of the replay counter.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- repeat  in  1  sampled when `deq` fires; when high, the current beat is (or remains) held for replay.
- enq_valid  in  1  upstream beat valid.
- enq_ready  out  1  block can accept the upstream beat.
- enq_opcode  in  3  A-channel opcode.
- enq_param  in  3  A-channel param.
- enq_size  in  SIZE_W  A-channel size.
- enq_source  in  SOURCE_W  A-channel source.
- enq_address  in  ADDR_W  A-channel address.
- enq_mask  in  DATA_W/8  A-channel byte mask.
- enq_data  in  DATA_W  A-channel data.
- enq_corrupt  in  1  A-channel corrupt flag.
- deq_valid  out  1  downstream beat valid.
- deq_ready  in  1  downstream accepts the beat.
- deq_opcode, deq_param, deq_size, deq_source, deq_address, deq_mask, deq_data, deq_corrupt  out  (same widths as enq_*)  downstream beat fields.
- full  out  1  a beat is held for replay.
- replay_cnt  out  CNT_W  number of `deq` fires served from the held beat.
- proto_err  out  1  sticky flag: `repeat` was seen high with `deq_valid` low.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - `full`=0, `replay_cnt`=0, `proto_err`=0.
  - The saved-beat register is not reset.
  - Outputs are then combinational: `deq_valid`=`enq_valid`, `enq_ready`=`deq_ready`.
  - Reset mid-replay discards the held beat; nothing further is issued for it.
- Combinational paths:
  - deq_valid = enq_valid | full.
  - enq_ready = deq_ready & ~full.
  - deq_* = full ? saved_* : enq_*.
  - Zero latency; no register on the pass-through path.
- Capture: `enq` fire (enq_valid & enq_ready) with repeat=1 → `full`←1 and `saved`←all enq_* fields, bit-exact.
- Release: `deq` fire with repeat=0 while full=1 → `full`←0 at the next edge.
- Hold: `deq` fire with repeat=1 while full=1 → `full` stays 1 and `saved` is unchanged.
- Back-pressure: `deq_ready`=0 changes no state, whatever `repeat` is.
- State machine, two states:
  - EMPTY → FULL on enq fire & repeat.
  - FULL → EMPTY on deq fire & ~repeat.
  - FULL → FULL on any other event.
  - EMPTY → EMPTY otherwise, including an enq fire with repeat=0 (pure pass-through).
- Simultaneous events: `enq` and `deq` fire in the same cycle only in EMPTY, because `enq_ready` requires ~full. The capture rule above applies in that case.
- Replay counter:
  - `replay_cnt` increments on every deq fire while full=1 and saturates at 2^CNT_W−1.
  - It clears to 0 on the EMPTY→FULL transition.
  - It holds its value after the FULL→EMPTY transition, for observability.
- Protocol error: `proto_err` sets when repeat=1 and deq_valid=0 in any cycle, and clears only on reset.
- Mask: passed through unmodified. The block neither checks nor fixes a partial mask; a partial mask is the downstream checker's concern.

Decomposition:
- Shared package `tl_a_pkg`:
  - Packed struct `tl_a_beat_t` {opcode, param, size, source, address, mask, data, corrupt}.
  - Opcode constants: PutFull=0, PutPartial=1, Get=4.
  - Width localparams.
- Optional sub-module `sat_counter` (parameterised width; inputs: increment, clear; output: count) for `replay_cnt`.
- The rest is flat.

Test Plan:
1. Pass-through: repeat=0, enq Get with addr=0x8000_0010, mask=0xF, deq_ready=1 → deq_* equals enq_* in the same cycle; full stays 0; replay_cnt=0.
2. Capture and replay:
   - Stimulus: enq PutFull addr=0x1000, data=0xDEAD_BEEF, mask=0xF with repeat=1 for 3 deq fires, then repeat=0 on the 4th.
   - Response: full=1 from the cycle after capture; enq_ready=0 while full; four deq beats with identical fields; full=0 after the 4th fire; replay_cnt=4.
3. Back-pressure: full=1 and deq_ready=0 for 5 cycles while enq fields change → deq_* stays at the saved values; replay_cnt is unchanged.
4. Reset mid-replay: full=1, replay_cnt=2, reset_n=0 for one edge → full=0, replay_cnt=0, proto_err=0; deq_valid follows enq_valid.
5. Saturation: CNT_W=2, hold repeat=1 for 6 deq fires → replay_cnt reads 1, 2, 3, 3, 3, 3.
6. Protocol error: repeat=1 with enq_valid=0 and full=0 → proto_err=1 from the next edge, and stays 1 until reset.

Source files
------------

// File: rtl/tl_a_pkg.sv
// Shared TileLink A-channel types and constants for the repeater and its bench.
package tl_a_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = DATA_W / 8;
    localparam int SOURCE_W   = 4;
    localparam int SIZE_W     = 3;
    localparam int CNT_W_DEF  = 8;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_W-1:0]   mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } tl_a_beat_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rep_state_t;

endpackage

// File: rtl/tl_a_repeater_if.sv
// Valid/ready A-channel link carrying one packed beat; the master drives valid and beat.
interface tl_a_repeater_if;
    import tl_a_pkg::*;

    logic       valid;
    logic       ready;
    tl_a_beat_t beat;

    modport master (output valid, output beat, input ready);
    modport slave  (input valid, input beat, output ready);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            w_count_next = r_count + W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tl_a_repeater.sv
// Single-entry A-channel repeater: zero-latency pass-through, or replays a captured
// beat on deq for as long as i_repeat is held at each deq fire.
module tl_a_repeater
    import tl_a_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_repeat,
    tl_a_repeater_if.slave   enq,
    tl_a_repeater_if.master  deq,
    output logic             o_full,
    output logic [CNT_W-1:0] o_replay_cnt,
    output logic             o_proto_err
);

    rep_state_t r_state;
    rep_state_t w_state_next;
    tl_a_beat_t r_saved;
    logic       r_proto_err;

    logic w_full;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_capture;

    assign w_full     = (r_state == ST_FULL);
    assign w_enq_fire = enq.valid & enq.ready;
    assign w_deq_fire = deq.valid & deq.ready;
    // enq can only fire while empty, so a capture never collides with a replay fire.
    assign w_capture  = w_enq_fire & i_repeat;

    assign deq.valid = enq.valid | w_full;
    assign enq.ready = deq.ready & ~w_full;
    assign deq.beat  = w_full ? r_saved : enq.beat;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_capture)                w_state_next = ST_FULL;
            ST_FULL:  if (w_deq_fire && !i_repeat)  w_state_next = ST_EMPTY;
            default:                                w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= ST_EMPTY;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_proto_err <= r_proto_err | (i_repeat & ~deq.valid);
        end
    end

    // Payload store deliberately has no reset; it is only observable while full.
    always_ff @(posedge i_clock) begin
        if (w_capture) begin
            r_saved <= enq.beat;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_replay_cnt (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_inc     (w_deq_fire & w_full),
        .i_clr     (w_capture),
        .o_count   (o_replay_cnt)
    );

    assign o_full      = w_full;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_tl_a_repeater.sv
// Directed bench for tl_a_repeater: pass-through, capture/replay, back-pressure,
// reset mid-replay, counter saturation (CNT_W=2 instance) and protocol error.
module tb_tl_a_repeater;
    import tl_a_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       rpt, rpt2;
    logic       full, full2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       perr, perr2;

    tl_a_repeater_if enq_if ();
    tl_a_repeater_if deq_if ();
    tl_a_repeater_if enq2_if ();
    tl_a_repeater_if deq2_if ();

    tl_a_repeater #(.CNT_W(8)) dut (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_repeat     (rpt),
        .enq          (enq_if),
        .deq          (deq_if),
        .o_full       (full),
        .o_replay_cnt (cnt),
        .o_proto_err  (perr)
    );

    tl_a_repeater #(.CNT_W(2)) dut2 (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_repeat     (rpt2),
        .enq          (enq2_if),
        .deq          (deq2_if),
        .o_full       (full2),
        .o_replay_cnt (cnt2),
        .o_proto_err  (perr2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic tl_a_beat_t mk(input logic [2:0] op, input logic [31:0] addr,
                                      input logic [31:0] data, input logic [3:0] mask,
                                      input logic [3:0] src);
        tl_a_beat_t b;
        b.opcode  = op;
        b.param   = 3'd0;
        b.size    = 3'd2;
        b.source  = src;
        b.address = addr;
        b.mask    = mask;
        b.data    = data;
        b.corrupt = 1'b0;
        return b;
    endfunction

    tl_a_beat_t b1, b2, b3, junk;
    logic [1:0] sat_exp [6];

    initial begin
        b1   = mk(OP_GET,         32'h8000_0010, 32'h0000_0000, 4'hF, 4'd3);
        b2   = mk(OP_PUT_FULL,    32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 4'd5);
        b3   = mk(OP_PUT_PARTIAL, 32'h0000_2000, 32'h1234_5678, 4'h3, 4'd7);
        junk = mk(OP_GET,         32'hFFFF_0000, 32'hA5A5_A5A5, 4'hF, 4'd9);
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        reset_n = 1'b0;
        rpt = 1'b0;  rpt2 = 1'b0;
        enq_if.valid = 1'b0;  enq_if.beat = '0;  deq_if.ready = 1'b0;
        enq2_if.valid = 1'b0; enq2_if.beat = '0; deq2_if.ready = 1'b0;
        tick();
        tick();
        check("rst_full", full, 1'b0);
        check("rst_cnt", cnt, 8'd0);
        check("rst_perr", perr, 1'b0);
        reset_n = 1'b1;

        // 1: pass-through
        enq_if.valid = 1'b1; enq_if.beat = b1; deq_if.ready = 1'b1; rpt = 1'b0;
        #1;
        check("pt_deq_valid", deq_if.valid, 1'b1);
        check("pt_deq_beat", deq_if.beat, b1);
        check("pt_enq_ready", enq_if.ready, 1'b1);
        tick();
        check("pt_full", full, 1'b0);
        check("pt_cnt", cnt, 8'd0);

        // 2: capture and replay
        enq_if.beat = b2; rpt = 1'b1;
        #1;
        check("cap_deq_beat", deq_if.beat, b2);
        tick();
        enq_if.beat = junk;
        #1;
        check("cap_full", full, 1'b1);
        check("cap_enq_ready", enq_if.ready, 1'b0);
        check("cap_cnt", cnt, 8'd0);
        for (int i = 0; i < 3; i++) begin
            check("rep_deq_beat", deq_if.beat, b2);
            check("rep_deq_valid", deq_if.valid, 1'b1);
            tick();
            check("rep_cnt", cnt, 128'(i + 1));
            check("rep_full", full, 1'b1);
        end
        rpt = 1'b0;
        #1;
        check("rel_deq_beat", deq_if.beat, b2);
        tick();
        check("rel_full", full, 1'b0);
        check("rel_cnt", cnt, 8'd4);
        enq_if.valid = 1'b0;

        // 3: back-pressure while full
        enq_if.valid = 1'b1; enq_if.beat = b3; rpt = 1'b1;
        tick();
        check("bp_cap_cnt", cnt, 8'd0);
        tick();
        check("bp_cnt1", cnt, 8'd1);
        deq_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_if.beat = mk(OP_GET, 32'h3000 + 32'(i), 32'(i), 4'hF, 4'(i));
            rpt = i[0];
            tick();
            check("bp_deq_beat", deq_if.beat, b3);
            check("bp_cnt", cnt, 8'd1);
            check("bp_full", full, 1'b1);
        end

        // 4: reset mid-replay
        deq_if.ready = 1'b1; rpt = 1'b1;
        tick();
        check("mid_cnt2", cnt, 8'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; rpt = 1'b0; enq_if.valid = 1'b0;
        #1;
        check("mrst_full", full, 1'b0);
        check("mrst_cnt", cnt, 8'd0);
        check("mrst_perr", perr, 1'b0);
        check("mrst_deq_valid0", deq_if.valid, 1'b0);
        enq_if.valid = 1'b1; enq_if.beat = b1;
        #1;
        check("mrst_deq_valid1", deq_if.valid, 1'b1);
        check("mrst_deq_beat", deq_if.beat, b1);
        deq_if.ready = 1'b0;
        #1;
        check("mrst_enq_ready", enq_if.ready, 1'b0);

        // 6: protocol error
        enq_if.valid = 1'b0; deq_if.ready = 1'b1; rpt = 1'b1;
        #1;
        check("perr_before", perr, 1'b0);
        tick();
        check("perr_set", perr, 1'b1);
        rpt = 1'b0;
        tick();
        tick();
        check("perr_sticky", perr, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("perr_clr", perr, 1'b0);

        // 5: saturation on the CNT_W=2 instance
        enq2_if.valid = 1'b1; enq2_if.beat = b2; deq2_if.ready = 1'b1; rpt2 = 1'b1;
        tick();
        enq2_if.valid = 1'b0;
        check("sat_full", full2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sat_cnt", cnt2, sat_exp[i]);
        end
        rpt2 = 1'b0;
        tick();
        check("sat_rel_full", full2, 1'b0);
        check("sat_rel_cnt", cnt2, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
